// File: rtl/rv_multicycle_ctrl_if.sv
// Control bundle between the RV32I IR decode/datapath and the multi-cycle
// sequencer: instruction fields and memory handshake in, enables and selects out.
interface rv_multicycle_ctrl_if #(
  parameter int ALU_OP_W = 4
);
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic                zero;
  logic                mem_ready;

  logic [ALU_OP_W-1:0] alu_op;
  logic                rs2_imm_s;
  logic [1:0]          w_data_s;
  logic [1:0]          pc_src;
  logic                pc_write;
  logic                ir_write;
  logic                reg_write;
  logic                mem_read;
  logic                mem_write;
  logic                retire;
  logic [1:0]          trap_cause;
  logic [3:0]          state;

  // The sequencer is the master: it consumes decode/handshake and drives the datapath.
  modport master (
    input  opcode, funct3, funct7, zero, mem_ready,
    output alu_op, rs2_imm_s, w_data_s, pc_src, pc_write, ir_write,
           reg_write, mem_read, mem_write, retire, trap_cause, state
  );

  modport slave (
    output opcode, funct3, funct7, zero, mem_ready,
    input  alu_op, rs2_imm_s, w_data_s, pc_src, pc_write, ir_write,
           reg_write, mem_read, mem_write, retire, trap_cause, state
  );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I teaching core: R/I/LUI/LW/SW/BEQ/BNE/JAL,
// ready-handshaked memory with an optional wait timeout, and a sticky trap state.
module rv_multicycle_ctrl #(
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rv_multicycle_ctrl_if.master bus
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_WB_ALU   = 4'd4;
  localparam logic [3:0] S_EXEC_I   = 4'd5;
  localparam logic [3:0] S_LUI      = 4'd6;
  localparam logic [3:0] S_MEM_ADDR = 4'd7;
  localparam logic [3:0] S_MEM_RD   = 4'd8;
  localparam logic [3:0] S_MEM_WB   = 4'd9;
  localparam logic [3:0] S_MEM_WR   = 4'd10;
  localparam logic [3:0] S_BRANCH   = 4'd11;
  localparam logic [3:0] S_JAL      = 4'd12;
  localparam logic [3:0] S_TRAP     = 4'd13;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

  // A zero MEM_TIMEOUT still needs a 1-bit counter so the logic elaborates.
  localparam int              CNT_W    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;
  localparam logic            TO_EN    = (MEM_TIMEOUT > 0);

  logic [3:0]          r_state;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [1:0]          r_trap_cause;

  logic [3:0]          w_next;
  logic [1:0]          w_trap_set;
  logic                w_wait_state;
  logic                w_timeout;
  logic                w_is_mem;
  logic                w_is_branch;

  logic [ALU_OP_W-1:0] w_alu_op;
  logic                w_rs2_imm_s;
  logic [1:0]          w_data_s;
  logic [1:0]          w_pc_src;
  logic                w_pc_write;
  logic                w_ir_write;
  logic                w_reg_write;
  logic                w_mem_read;
  logic                w_mem_write;
  logic                w_retire;

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // mem_ready in the final allowed cycle completes the access instead of trapping.
  assign w_timeout    = TO_EN && w_wait_state && !bus.mem_ready && (r_wait_cnt == CNT_LAST);
  assign w_is_mem     = ((bus.opcode == 7'b0000011) || (bus.opcode == 7'b0100011)) &&
                        (bus.funct3 == 3'b010);
  assign w_is_branch  = (bus.opcode == 7'b1100011) &&
                        ((bus.funct3 == 3'b000) || (bus.funct3 == 3'b001));

  always_comb begin
    w_next     = r_state;
    w_trap_set = TRAP_NONE;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH: begin
        if (w_timeout) begin
          w_next     = S_TRAP;
          w_trap_set = TRAP_TIMEOUT;
        end else if (bus.mem_ready) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (bus.opcode == 7'b0110011)      w_next = S_EXEC_R;
        else if (bus.opcode == 7'b0010011) w_next = S_EXEC_I;
        else if (bus.opcode == 7'b0110111) w_next = S_LUI;
        else if (w_is_mem)                 w_next = S_MEM_ADDR;
        else if (w_is_branch)              w_next = S_BRANCH;
        else if (bus.opcode == 7'b1101111) w_next = S_JAL;
        else begin
          w_next     = S_TRAP;
          w_trap_set = TRAP_ILLEGAL;
        end
      end
      S_EXEC_R, S_EXEC_I: w_next = S_WB_ALU;
      S_WB_ALU, S_LUI, S_MEM_WB, S_BRANCH, S_JAL: w_next = S_FETCH;
      S_MEM_ADDR: w_next = bus.opcode[5] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (w_timeout) begin
          w_next     = S_TRAP;
          w_trap_set = TRAP_TIMEOUT;
        end else if (bus.mem_ready) begin
          w_next = S_MEM_WB;
        end
      end
      S_MEM_WR: begin
        if (w_timeout) begin
          w_next     = S_TRAP;
          w_trap_set = TRAP_TIMEOUT;
        end else if (bus.mem_ready) begin
          w_next = S_FETCH;
        end
      end
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_IDLE;
    endcase
  end

  // The wait counter restarts whenever the state changes, so every wait state starts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_trap_cause <= TRAP_NONE;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait_cnt <= '0;
      else if (w_wait_state && !bus.mem_ready)
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      if ((r_trap_cause == TRAP_NONE) && (w_trap_set != TRAP_NONE))
        r_trap_cause <= w_trap_set;
    end
  end

  always_comb begin
    w_alu_op    = '0;
    w_rs2_imm_s = 1'b0;
    w_data_s    = 2'b00;
    w_pc_src    = 2'b00;
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_ir_write = bus.mem_ready;
        w_pc_write = bus.mem_ready;
      end
      S_EXEC_R: w_alu_op[3:0] = {bus.funct7[5], bus.funct3};
      S_EXEC_I: begin
        w_rs2_imm_s   = 1'b1;
        w_alu_op[3:0] = (bus.funct3 == 3'b101) ? {bus.funct7[5], bus.funct3} : {1'b0, bus.funct3};
      end
      S_WB_ALU: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_LUI: begin
        w_reg_write = 1'b1;
        w_data_s    = 2'b01;
        w_retire    = 1'b1;
      end
      S_MEM_ADDR: w_rs2_imm_s = 1'b1;
      S_MEM_RD:   w_mem_read  = 1'b1;
      S_MEM_WB: begin
        w_reg_write = 1'b1;
        w_data_s    = 2'b10;
        w_retire    = 1'b1;
      end
      S_MEM_WR: begin
        w_mem_write = 1'b1;
        w_retire    = bus.mem_ready;
      end
      S_BRANCH: begin
        w_alu_op[3:0] = 4'b1000;
        w_pc_src      = 2'b01;
        w_pc_write    = ((bus.funct3 == 3'b000) && bus.zero) ||
                        ((bus.funct3 == 3'b001) && !bus.zero);
        w_retire      = 1'b1;
      end
      S_JAL: begin
        w_reg_write = 1'b1;
        w_data_s    = 2'b11;
        w_pc_write  = 1'b1;
        w_pc_src    = 2'b10;
        w_retire    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.alu_op     = w_alu_op;
  assign bus.rs2_imm_s  = w_rs2_imm_s;
  assign bus.w_data_s   = w_data_s;
  assign bus.pc_src     = w_pc_src;
  assign bus.pc_write   = w_pc_write;
  assign bus.ir_write   = w_ir_write;
  assign bus.reg_write  = w_reg_write;
  assign bus.mem_read   = w_mem_read;
  assign bus.mem_write  = w_mem_write;
  assign bus.retire     = w_retire;
  assign bus.trap_cause = r_trap_cause;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Bench for rv_multicycle_ctrl: table of instructions checked through a retire
// scoreboard, plus hand-written reset, trap and timeout sequences.
module tb_rv_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rv_multicycle_ctrl_if #(.ALU_OP_W(4)) bus ();

  rv_multicycle_ctrl #(.ALU_OP_W(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string      name;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    int         fetchWait;
    int         memWait;
    int         expLat;
    int         expState;
    int         expAlu;
    int         expImm;
    int         expRegW;
    int         expMemRd;
    int         expMemWr;
    int         expWdata;
    int         expPcw;
    int         expPcSrc;
    int         expPcWrites;
  } vec_t;

  vec_t tbl[$];
  vec_t expQ[$];
  int   checks = 0;
  int   fails  = 0;

  function automatic int allOut();
    return int'({bus.alu_op, bus.rs2_imm_s, bus.w_data_s, bus.pc_src, bus.pc_write,
                 bus.ir_write, bus.reg_write, bus.mem_read, bus.mem_write, bus.retire,
                 bus.trap_cause, bus.state});
  endfunction

  task automatic checkOutput(input string what, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", what, act, exp);
    end
  endtask

  task automatic resetDut(input int n);
    rst           = 1'b1;
    bus.mem_ready = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic setFields(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic z);
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.zero   = z;
  endtask

  // Runs one instruction from FETCH entry to its retire pulse and scores it.
  task automatic applyStimulus(input vec_t v);
    int cyc = 0, waitCnt = 0, retires = 0, regW = 0, mrd = 0, mwr = 0, pcws = 0;
    int exState = -1, exAlu = -1, exImm = -1, wd = -1, pcw = -1, pcs = -1;
    logic [3:0] prevState = 4'hF;
    bit done = 0;
    vec_t e;
    expQ.push_back(v);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      setFields(v.opcode, v.funct3, v.funct7, v.zero);
      if (bus.state != prevState) waitCnt = 0;
      prevState = bus.state;
      case (bus.state)
        4'd1:        bus.mem_ready = (waitCnt >= v.fetchWait);
        4'd8, 4'd10: bus.mem_ready = (waitCnt >= v.memWait);
        default:     bus.mem_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (!bus.mem_ready) waitCnt++;
      if (bus.state == 4'd13) break;
      if (bus.state != 4'd0) cyc++;
      retires += int'(bus.retire);
      regW    += int'(bus.reg_write);
      mrd     += int'(bus.mem_read);
      mwr     += int'(bus.mem_write);
      pcws    += int'(bus.pc_write);
      if (exState < 0 && bus.state > 4'd2) begin
        exState = int'(bus.state);
        exAlu   = int'(bus.alu_op);
        exImm   = int'(bus.rs2_imm_s);
      end
      if (bus.retire) begin
        wd   = int'(bus.w_data_s);
        pcw  = int'(bus.pc_write);
        pcs  = int'(bus.pc_src);
        done = 1;
      end
    end
    if (expQ.size() == 0) begin
      checkOutput({v.name, " scoreboard empty"}, 0, 1);
    end else begin
      e = expQ.pop_front();
      checkOutput({e.name, " retired"}, int'(done), 1);
      if (done) begin
        checkOutput({e.name, " latency"}, cyc, e.expLat);
        checkOutput({e.name, " exec state"}, exState, e.expState);
        checkOutput({e.name, " alu_op"}, exAlu, e.expAlu);
        checkOutput({e.name, " rs2_imm_s"}, exImm, e.expImm);
        checkOutput({e.name, " retire count"}, retires, 1);
        checkOutput({e.name, " reg_write cycles"}, regW, e.expRegW);
        checkOutput({e.name, " mem_read cycles"}, mrd, e.expMemRd);
        checkOutput({e.name, " mem_write cycles"}, mwr, e.expMemWr);
        checkOutput({e.name, " w_data_s"}, wd, e.expWdata);
        checkOutput({e.name, " pc_write at retire"}, pcw, e.expPcw);
        checkOutput({e.name, " pc_src at retire"}, pcs, e.expPcSrc);
        checkOutput({e.name, " pc_write cycles"}, pcws, e.expPcWrites);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad, rets, cnt;
    setFields(7'd0, 3'd0, 7'd0, 1'b0);
    //              name    opcode      f3      f7          z  fw mw lat st alu imm rw rd wr wd pcw pcs pcws
    tbl.push_back('{"ADD",  7'b0110011, 3'b000, 7'b0000000, 0, 0, 0, 4,  3, 0,  0,  1, 1, 0, 0, 0,  0,  1});
    tbl.push_back('{"SUB",  7'b0110011, 3'b000, 7'b0100000, 0, 0, 0, 4,  3, 8,  0,  1, 1, 0, 0, 0,  0,  1});
    tbl.push_back('{"SRL",  7'b0110011, 3'b101, 7'b0000000, 1, 0, 0, 4,  3, 5,  0,  1, 1, 0, 0, 0,  0,  1});
    tbl.push_back('{"SRAI", 7'b0010011, 3'b101, 7'b0100000, 0, 0, 0, 4,  5, 13, 1,  1, 1, 0, 0, 0,  0,  1});
    tbl.push_back('{"ADDI", 7'b0010011, 3'b000, 7'b1111111, 0, 0, 0, 4,  5, 0,  1,  1, 1, 0, 0, 0,  0,  1});
    tbl.push_back('{"SLTIU",7'b0010011, 3'b011, 7'b0100000, 0, 0, 0, 4,  5, 3,  1,  1, 1, 0, 0, 0,  0,  1});
    tbl.push_back('{"LUI",  7'b0110111, 3'b000, 7'b0000000, 0, 0, 0, 3,  6, 0,  0,  1, 1, 0, 1, 0,  0,  1});
    tbl.push_back('{"LW3",  7'b0000011, 3'b010, 7'b0000000, 0, 0, 3, 8,  7, 0,  1,  1, 5, 0, 2, 0,  0,  1});
    tbl.push_back('{"LWF1", 7'b0000011, 3'b010, 7'b0000000, 0, 1, 0, 6,  7, 0,  1,  1, 3, 0, 2, 0,  0,  1});
    tbl.push_back('{"SW2",  7'b0100011, 3'b010, 7'b0000000, 0, 0, 2, 6,  7, 0,  1,  0, 1, 3, 0, 0,  0,  1});
    tbl.push_back('{"BEQz1",7'b1100011, 3'b000, 7'b0000000, 1, 0, 0, 3, 11, 8,  0,  0, 1, 0, 0, 1,  1,  2});
    tbl.push_back('{"BNEz1",7'b1100011, 3'b001, 7'b0000000, 1, 0, 0, 3, 11, 8,  0,  0, 1, 0, 0, 0,  1,  1});
    tbl.push_back('{"BEQz0",7'b1100011, 3'b000, 7'b0000000, 0, 0, 0, 3, 11, 8,  0,  0, 1, 0, 0, 0,  1,  1});
    tbl.push_back('{"BNEz0",7'b1100011, 3'b001, 7'b0000000, 0, 0, 0, 3, 11, 8,  0,  0, 1, 0, 0, 1,  1,  2});
    tbl.push_back('{"JAL",  7'b1101111, 3'b000, 7'b0000000, 0, 0, 0, 3, 12, 0,  0,  1, 1, 0, 3, 1,  2,  2});
    tbl.push_back('{"ADDF2",7'b0110011, 3'b000, 7'b0000000, 0, 2, 0, 6,  3, 0,  0,  1, 3, 0, 0, 0,  0,  1});

    $display("[TB] reset and instruction table");
    resetDut(2);
    #1;
    checkOutput("reset outputs", allOut(), 0);
    foreach (tbl[i]) applyStimulus(tbl[i]);

    $display("[TB] illegal opcode trap");
    resetDut(1);
    rets = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      setFields(7'b1110011, 3'b000, 7'b0000000, 1'b0);
      bus.mem_ready = 1'b1;
      #1;
      rets += int'(bus.retire);
    end
    checkOutput("illegal state", int'(bus.state), 13);
    checkOutput("illegal trap_cause", int'(bus.trap_cause), 1);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      rets += int'(bus.retire);
      if (allOut() != 32'h1D) bad++;
    end
    checkOutput("trap hold bad cycles", bad, 0);
    checkOutput("trap retire pulses", rets, 0);
    resetDut(1);
    #1;
    checkOutput("trap cleared by reset", allOut(), 0);
    @(negedge clk);
    #1;
    checkOutput("fetch after trap reset", int'(bus.state), 1);

    $display("[TB] fetch timeout");
    resetDut(1);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      setFields(7'b0110011, 3'b000, 7'b0000000, 1'b0);
      bus.mem_ready = 1'b0;
      #1;
      cnt += int'(bus.mem_read && bus.state == 4'd1);
    end
    checkOutput("fetch wait mem_read cycles", cnt, 4);
    @(negedge clk);
    #1;
    checkOutput("fetch timeout state", int'(bus.state), 13);
    checkOutput("fetch timeout cause", int'(bus.trap_cause), 2);

    $display("[TB] ready on last allowed fetch cycle");
    resetDut(1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.mem_ready = (c == 3);
      #1;
    end
    checkOutput("late ready ir_write", int'(bus.ir_write), 1);
    @(negedge clk);
    #1;
    checkOutput("late ready state", int'(bus.state), 2);
    checkOutput("late ready cause", int'(bus.trap_cause), 0);

    $display("[TB] store timeout");
    resetDut(1);
    cnt  = 0;
    rets = 0;
    for (int c = 0; c < 20 && bus.state != 4'd13; c++) begin
      @(negedge clk);
      setFields(7'b0100011, 3'b010, 7'b0000000, 1'b0);
      bus.mem_ready = (bus.state == 4'd1);
      #1;
      cnt  += int'(bus.mem_write);
      rets += int'(bus.retire);
    end
    checkOutput("store timeout state", int'(bus.state), 13);
    checkOutput("store timeout cause", int'(bus.trap_cause), 2);
    checkOutput("store timeout mem_write cycles", cnt, 4);
    checkOutput("store timeout retires", rets, 0);

    $display("[TB] reset during load wait");
    resetDut(1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      setFields(7'b0000011, 3'b010, 7'b0000000, 1'b0);
      bus.mem_ready = (c == 0);
      #1;
    end
    checkOutput("load wait state", int'(bus.state), 8);
    @(negedge clk);
    rst           = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("abort outputs", allOut(), 0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
